// File: rtl/sumador_adivino.sv
// Registered 4-bit carry-lookahead adder with group generate/propagate outputs.
// Carries are flattened two-level sum-of-products of g/p; no ripple path.
module sumador_adivino (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       in_valid,
   output logic [4:0] res,
   output logic       out_valid,
   output logic       g_out,
   output logic       p_out
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;
   logic [3:0] s;

   logic [4:0] res_q, res_d;
   logic       out_valid_q, out_valid_d;
   logic       g_out_q, g_out_d;
   logic       p_out_q, p_out_d;

   always_comb begin
      g = a & b;
      p = a ^ b;

      c[0] = 1'b0;
      c[1] = g[0];
      c[2] = g[1] | (p[1] & g[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

      s = p ^ c[3:0];
   end

   // Result and group flags only load on a sampled beat; out_valid marks fresh data.
   always_comb begin
      res_d       = res_q;
      g_out_d     = g_out_q;
      p_out_d     = p_out_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         res_d       = {c[4], s};
         g_out_d     = c[4];
         p_out_d     = &p;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q       <= 5'b00000;
         out_valid_q <= 1'b0;
         g_out_q     <= 1'b0;
         p_out_q     <= 1'b0;
      end else begin
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         g_out_q     <= g_out_d;
         p_out_q     <= p_out_d;
      end
   end

   assign res       = res_q;
   assign out_valid = out_valid_q;
   assign g_out     = g_out_q;
   assign p_out     = p_out_q;

endmodule

// File: tb/tb_sumador_adivino.sv
// Self-checking bench for sumador_adivino: directed steps plus random and exhaustive
// operands compared against an arithmetic reference model.
module tb_sumador_adivino;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       in_valid;
   logic [4:0] res;
   logic       out_valid;
   logic       g_out;
   logic       p_out;

   int vectors;
   int miscompares;

   logic [4:0] exp_res;
   logic       exp_ov;
   logic       exp_g;
   logic       exp_p;

   sumador_adivino dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .in_valid (in_valid),
      .res      (res),
      .out_valid(out_valid),
      .g_out    (g_out),
      .p_out    (p_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".res"}, res, exp_res);
      check({tag, ".out_valid"}, {4'b0, out_valid}, {4'b0, exp_ov});
      check({tag, ".g_out"}, {4'b0, g_out}, {4'b0, exp_g});
      check({tag, ".p_out"}, {4'b0, p_out}, {4'b0, exp_p});
   endtask

   task automatic model_reset();
      exp_res = '0;
      exp_ov  = 1'b0;
      exp_g   = 1'b0;
      exp_p   = 1'b0;
   endtask

   // Reference: plain integer addition; generate = carry out, propagate = all bits differ.
   task automatic model_step(input logic [3:0] ta, input logic [3:0] tb_, input logic tv);
      int sum;
      if (tv) begin
         sum     = int'(ta) + int'(tb_);
         exp_res = 5'(sum);
         exp_g   = (sum > 15);
         exp_p   = ((ta ^ tb_) == 4'hF);
         exp_ov  = 1'b1;
      end else begin
         exp_ov  = 1'b0;
      end
   endtask

   task automatic step(input logic [3:0] ta, input logic [3:0] tb_, input logic tv,
                       input string tag);
      @(negedge clk);
      a        = ta;
      b        = tb_;
      in_valid = tv;
      @(posedge clk);
      model_step(ta, tb_, tv);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [3:0] seq_a [6];
      logic [3:0] seq_b [6];
      logic [4:0] seq_r [6];
      vectors     = 0;
      miscompares = 0;
      seq_a = '{4'd0, 4'd4, 4'd4, 4'd4,  4'd3,  4'd12};
      seq_b = '{4'd0, 4'd5, 4'd7, 4'd11, 4'd15, 4'd11};
      seq_r = '{5'b00000, 5'b01001, 5'b01011, 5'b01111, 5'b10010, 5'b10111};

      // Reset held with random activity on the inputs.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 4'($urandom);
      b        = 4'($urandom);
      model_reset();
      #1;
      check_all("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a        = 4'($urandom);
         b        = 4'($urandom);
         in_valid = 1'($urandom);
         @(posedge clk);
         #1;
         check_all("reset_held");
      end

      // Deassert; first edge after release samples normally.
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(seq_a[i], seq_b[i], 1'b1, "sum_seq");
         check("sum_seq.const", res, seq_r[i]);
         check("sum_seq.ov", {4'b0, out_valid}, 5'd1);
      end

      step(4'hF, 4'h0, 1'b1, "group_prop");
      check("group_prop.res", res, 5'b01111);
      check("group_prop.p", {4'b0, p_out}, 5'd1);
      check("group_prop.g", {4'b0, g_out}, 5'd0);
      step(4'hF, 4'h1, 1'b1, "group_gen");
      check("group_gen.res", res, 5'b10000);
      check("group_gen.g", {4'b0, g_out}, 5'd1);
      check("group_gen.p", {4'b0, p_out}, 5'd0);

      // Hold: operands change while in_valid is low.
      for (int i = 0; i < 6; i++) begin
         step(4'($urandom), 4'($urandom), 1'b0, "hold");
         check("hold.res", res, 5'b10000);
      end

      // Exhaustive back-to-back.
      for (int i = 0; i < 256; i++) begin
         step(4'(i >> 4), 4'(i), 1'b1, "exhaustive");
      end

      // Random mix of valid and idle cycles.
      for (int i = 0; i < 200; i++) begin
         step(4'($urandom), 4'($urandom), 1'($urandom), "random");
      end

      // Mid-stream reset clears outputs immediately, no clock edge needed.
      step(4'd9, 4'd8, 1'b1, "pre_reset");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("reset_mid");
      @(negedge clk);
      a        = 4'd7;
      b        = 4'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_all("reset_mid_held");
      @(negedge clk);
      rst_n = 1'b1;
      step(4'd6, 4'd13, 1'b1, "post_reset");
      step(4'd1, 4'd2, 1'b0, "post_reset_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sumador_adivino.md
SUMADOR_ADIVINO -- requirements
Module: sumador_adivino

Interface
REQ-001 Parameters: none; the datapath is fixed at 4-bit operands and a 5-bit result.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  4  unsigned operand A.
REQ-005 b  input  4  unsigned operand B.
REQ-006 in_valid  input  1  high = sample a/b on this rising edge.
REQ-007 res  output  5  registered unsigned sum; res[4] = carry-out.
REQ-008 out_valid  output  1  high for the cycle in which res holds a new sum.
REQ-009 g_out  output  1  registered group generate of the sampled operands.
REQ-010 p_out  output  1  registered group propagate of the sampled operands.

Function
REQ-011 The block SHALL be a carry-lookahead ("adivino") adder, with an implicit carry-in of 0.
REQ-012 Per-bit signals SHALL be g[i] = a[i] AND b[i] and p[i] = a[i] XOR b[i], for i = 0..3.
REQ-013 Carries SHALL use two-level lookahead equations from g/p only, with no ripple chain:
- c0 = 0
- c1 = g0
- c2 = g1 | p1g0
- c3 = g2 | p2g1 | p2p1g0
- c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0
REQ-014 Sum bits SHALL be s[i] = p[i] XOR c[i], and res SHALL equal {c4, s3..s0}.
REQ-015 The next res SHALL equal a + b exactly, modulo 32; the 4-bit sum never overflows 5 bits (maximum 15 + 15 = 30).
REQ-016 Group outputs:
- g_out SHALL equal c4.
- p_out SHALL equal p3 & p2 & p1 & p0.
REQ-017 Latency: on a rising edge with in_valid = 1, res, g_out and p_out SHALL load from that edge's a/b, and out_valid SHALL go to 1; the result is visible one cycle after sampling.
REQ-018 On a rising edge with in_valid = 0:
- res, g_out and p_out SHALL hold their values.
- out_valid SHALL go to 0.
REQ-019 Back-to-back in_valid = 1 SHALL produce one result per cycle with out_valid held at 1 (full throughput, no stalls).
REQ-020 Changes on a/b while in_valid = 0 SHALL have no effect on any output.
REQ-021 The block SHALL contain no state other than res, g_out, p_out and out_valid.

Reset
REQ-022 While rst_n = 0, res SHALL be 5'b00000, out_valid 0, g_out 0 and p_out 0, asynchronously and regardless of clk.
REQ-023 Deassertion of rst_n SHALL take effect at the next rising edge.
REQ-024 An in_valid = 1 coinciding with the first edge after deassertion SHALL be sampled normally.
REQ-025 Reset asserted mid-stream SHALL discard any result not yet presented.

Verification
REQ-026 The bench SHALL cover:
- Reset: rst_n = 0 with random a/b -> res = 0, out_valid = 0; also assert mid-stream -> immediate clear.
- Sum sequence: in_valid = 1 with 0+0, 4+5, 4+7, 4+11, 3+15, 12+11 -> res = 00000, 01001, 01011, 01111, 10010, 10111 on consecutive cycles, out_valid = 1 throughout.
- Group signals: a = 1111, b = 0000 -> res = 01111, p_out = 1, g_out = 0; a = 1111, b = 0001 -> res = 10000, g_out = 1, p_out = 0.
- Hold: in_valid = 0 with changing a/b -> res unchanged, out_valid = 0.
- Exhaustive: all 256 a/b pairs -> res == a + b each cycle.
